// File: rtl/lif_neuron_core_if.sv
// lif_neuron_core_if: synapse contribution stream from the SIP into the LIF soma
//   syn_valid  : contribution present this cycle          (master -> slave)
//   syn_ready  : soma accepts a contribution this cycle   (slave -> master)
//   syn_weight : unsigned weight magnitude                (master -> slave)
//   syn_excite : 1 = add weight, 0 = subtract weight      (master -> slave)
//   window_end : pulse marking the last synapse of window (master -> slave)
interface lif_neuron_core_if #(
    parameter int W_W = 4
);
    logic           syn_valid;
    logic           syn_ready;
    logic [W_W-1:0] syn_weight;
    logic           syn_excite;
    logic           window_end;
    modport master (output syn_valid, syn_weight, syn_excite, window_end, input syn_ready);
    modport slave  (input syn_valid, syn_weight, syn_excite, window_end, output syn_ready);
endinterface

// File: rtl/lif_neuron_core.sv
// lif_neuron_core: leaky integrate-and-fire soma with per-window leak, fire and refractory
//   clock_i      : rising-edge clock
//   reset_ni     : asynchronous active-low reset
//   enable_i     : 0 freezes all state and masks spike_out_o
//   syn          : contribution stream (lif_neuron_core_if.slave)
//   spike_out_o  : one-cycle fire pulse
//   membrane_o   : signed membrane potential
//   refractory_o : high while refractory windows remain
//   thr_out_o    : adaptive threshold, present only with ADAPTIVE_THRESHOLD_EN defined
module lif_neuron_core #(
    parameter int MEM_W      = 12,
    parameter int W_W        = 4,
    parameter int THRESHOLD  = 64,
    parameter int V_REST     = 0,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC_WIN = 2
) (
    input  logic                    clock_i,
    input  logic                    reset_ni,
    input  logic                    enable_i,
    lif_neuron_core_if.slave        syn,
    output logic                    spike_out_o,
    output logic signed [MEM_W-1:0] membrane_o,
    output logic                    refractory_o
`ifdef ADAPTIVE_THRESHOLD_EN
    ,
    output logic signed [MEM_W-1:0] thr_out_o
`endif
);
    localparam int RC_W = (REFRAC_WIN > 0) ? $clog2(REFRAC_WIN + 1) : 1;
    localparam logic signed [MEM_W-1:0] THR_C  = MEM_W'(THRESHOLD);
    localparam logic signed [MEM_W-1:0] REST_C = MEM_W'(V_REST);
    localparam logic signed [MEM_W-1:0] MAX_C  = {1'b0, {(MEM_W-1){1'b1}}};
    localparam logic signed [MEM_W-1:0] MIN_C  = {1'b1, {(MEM_W-1){1'b0}}};

    typedef enum logic {ACCUM, EVAL} state_t;

    state_t                  state_q, state_d;
    logic signed [MEM_W-1:0] mem_q, mem_d, v_l, thr_c, acc_sat;
    logic signed [MEM_W:0]   mem_x, w_ext, sum;
    logic [RC_W-1:0]         refr_q, refr_d;
    logic                    spike_q, spike_d, run_q, xfer, fire;

`ifdef ADAPTIVE_THRESHOLD_EN
    logic signed [MEM_W-1:0] thr_q, thr_d;
    logic signed [MEM_W:0]   thr_up;
    assign thr_up    = $signed({thr_q[MEM_W-1], thr_q}) + (MEM_W+1)'(8);
    assign thr_c     = thr_q;
    assign thr_out_o = thr_q;
`else
    assign thr_c = THR_C;
`endif

    // run_q keeps syn_ready low until the first edge after reset release
    assign syn.syn_ready = run_q & enable_i & (state_q == ACCUM);
    assign xfer          = syn.syn_valid & syn.syn_ready;
    assign mem_x         = $signed({mem_q[MEM_W-1], mem_q});
    assign w_ext         = $signed({{(MEM_W+1-W_W){1'b0}}, syn.syn_weight});
    assign sum           = syn.syn_excite ? mem_x + w_ext : mem_x - w_ext;
    // one extra bit of headroom: top two bits disagreeing means overflow
    assign acc_sat       = (sum[MEM_W] != sum[MEM_W-1]) ? (sum[MEM_W] ? MIN_C : MAX_C) : sum[MEM_W-1:0];
    // subtracting v>>>k from v cannot overflow, so no clamp is needed here
    assign v_l           = mem_q - (mem_q >>> LEAK_SHIFT);
    assign fire          = v_l >= thr_c;

    assign spike_out_o  = spike_q & enable_i;
    assign membrane_o   = mem_q;
    assign refractory_o = |refr_q;

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        refr_d  = refr_q;
        spike_d = spike_q;
`ifdef ADAPTIVE_THRESHOLD_EN
        thr_d   = thr_q;
`endif
        if (enable_i) begin
            spike_d = 1'b0;
            if (state_q == ACCUM) begin
                mem_d   = (xfer && refr_q == '0) ? acc_sat : mem_q;
                state_d = syn.window_end ? EVAL : ACCUM;
            end else begin
                state_d = ACCUM;
                if (refr_q != '0) begin
                    mem_d  = REST_C;
                    refr_d = refr_q - RC_W'(1);
                end else if (fire) begin
                    mem_d   = REST_C;
                    refr_d  = RC_W'(REFRAC_WIN);
                    spike_d = 1'b1;
`ifdef ADAPTIVE_THRESHOLD_EN
                    thr_d   = (thr_up[MEM_W] != thr_up[MEM_W-1]) ? MAX_C : thr_up[MEM_W-1:0];
`endif
                end else begin
                    mem_d = v_l;
`ifdef ADAPTIVE_THRESHOLD_EN
                    // threshold only decays on ordinary integrating windows, not refractory ones
                    thr_d = (thr_q > THR_C) ? thr_q - MEM_W'(1) : thr_q;
`endif
                end
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ACCUM;
            mem_q   <= REST_C;
            refr_q  <= '0;
            spike_q <= 1'b0;
            run_q   <= 1'b0;
`ifdef ADAPTIVE_THRESHOLD_EN
            thr_q   <= THR_C;
`endif
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            refr_q  <= refr_d;
            spike_q <= spike_d;
            run_q   <= 1'b1;
`ifdef ADAPTIVE_THRESHOLD_EN
            thr_q   <= thr_d;
`endif
        end
    end
endmodule

// File: tb/tb_lif_neuron_core.sv
// tb_lif_neuron_core: randomized and directed checks of the LIF soma against an integer model
module tb_lif_neuron_core;
    localparam int THR  = 64;
    localparam int MAXV = 2047;
    localparam int MINV = -2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic spike, refr;
    logic signed [11:0] mem;
`ifdef ADAPTIVE_THRESHOLD_EN
    logic signed [11:0] thr_o;
`endif

    lif_neuron_core_if #(.W_W(4)) syn_if ();

    lif_neuron_core dut (
        .clock_i     (clk),
        .reset_ni    (rst_n),
        .enable_i    (en),
        .syn         (syn_if),
        .spike_out_o (spike),
        .membrane_o  (mem),
        .refractory_o(refr)
`ifdef ADAPTIVE_THRESHOLD_EN
        ,
        .thr_out_o   (thr_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: membrane as a plain integer, refractory windows left, threshold
    int m, rc, th;
    bit m_eval, m_spike, m_run;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clamp(input int x);
        return (x > MAXV) ? MAXV : (x < MINV) ? MINV : x;
    endfunction

    // floor(x / 8): leak rounds toward minus infinity
    function automatic int floor8(input int x);
        return (x >= 0) ? x / 8 : -((-x + 7) / 8);
    endfunction

    task automatic step(input bit v, input int w, input bit e, input bit we, input bit en_i, output bit acc);
        bit exp_rdy;
        int vl;
        syn_if.syn_valid  = v;
        syn_if.syn_weight = 4'(w);
        syn_if.syn_excite = e;
        syn_if.window_end = we;
        en = en_i;
        #1;
        exp_rdy = m_run && en_i && !m_eval;
        check("ready", syn_if.syn_ready, exp_rdy);
        check("spike", spike, m_spike && en_i);
        acc = v && exp_rdy;
        @(posedge clk);
        m_run = 1'b1;
        if (en_i) begin
            if (m_eval) begin
                vl = m - floor8(m);
                m_eval = 1'b0;
                m_spike = 1'b0;
                if (rc > 0) begin
                    m = 0;
                    rc--;
                end else if (vl >= th) begin
                    m = 0;
                    rc = 2;
                    m_spike = 1'b1;
`ifdef ADAPTIVE_THRESHOLD_EN
                    th = (th + 8 > MAXV) ? MAXV : th + 8;
`endif
                end else begin
                    m = vl;
`ifdef ADAPTIVE_THRESHOLD_EN
                    if (th > THR) th--;
`endif
                end
            end else begin
                m_spike = 1'b0;
                if (acc && rc == 0) m = clamp(e ? m + w : m - w);
                if (we) m_eval = 1'b1;
            end
        end
        #1;
        check("membrane", mem, m);
        check("refractory", refr, rc > 0);
`ifdef ADAPTIVE_THRESHOLD_EN
        check("thr", thr_o, th);
`endif
        @(negedge clk);
    endtask

    task automatic idle(input bit we, input bit en_i);
        bit acc;
        step(1'b0, 0, 1'b0, we, en_i, acc);
    endtask

    // present one contribution until the model says it was taken
    task automatic send(input int w, input bit e, input bit we);
        bit acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) step(1'b1, w, e, we, 1'b1, acc);
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic window(input int n, input int w, input bit e);
        for (int i = 0; i < n; i++) send(w, e, i == n - 1);
    endtask

    task automatic do_reset();
        en = 1'b1;
        syn_if.syn_valid = 1'b1;
        syn_if.window_end = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mem", mem, 0);
        check("rst_spike", spike, 0);
        check("rst_ready", syn_if.syn_ready, 0);
        check("rst_refr", refr, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready_hold", syn_if.syn_ready, 0);
        rst_n = 1'b1;
        #1;
        check("ready_at_release", syn_if.syn_ready, 0);
        m = 0;
        rc = 0;
        th = THR;
        m_eval = 1'b0;
        m_spike = 1'b0;
        m_run = 1'b0;
        syn_if.syn_valid = 1'b0;
    endtask

    initial begin
        bit acc;
        int w;
        syn_if.syn_valid = 1'b0;
        syn_if.syn_weight = '0;
        syn_if.syn_excite = 1'b0;
        syn_if.window_end = 1'b0;
        @(negedge clk);
        do_reset();
        idle(1'b0, 1'b1);
        check("ready_rise", syn_if.syn_ready, 1);

        // sub-threshold window with leak; stray window_end during EVAL is ignored
        window(16, 3, 1'b1);
        check("accum48", mem, 48);
        idle(1'b1, 1'b1);
        check("leak42", mem, 42);
        check("no_spike42", spike, 0);
        check("eval_we_ignored", syn_if.syn_ready, 1);

        // fire at T+2 for exactly one cycle, then two refractory windows, then fire again
        do_reset();
        window(16, 5, 1'b1);
        check("accum80", mem, 80);
        check("spike_T1", spike, 0);
        idle(1'b0, 1'b1);
        check("spike_T2", spike, 1);
        check("fire_mem", mem, 0);
        check("fire_refr", refr, 1);
`ifdef ADAPTIVE_THRESHOLD_EN
        check("thr72", thr_o, 72);
`endif
        idle(1'b0, 1'b1);
        check("spike_T3", spike, 0);
        for (int i = 0; i < 2; i++) begin
            window(16, 15, 1'b1);
            check("refr_accum", mem, 0);
            idle(1'b0, 1'b1);
            check("refr_nospike", spike, 0);
        end
        check("refr_dropped", refr, 0);
        window(16, 15, 1'b1);
        idle(1'b0, 1'b1);
        check("refire", spike, 1);

`ifdef ADAPTIVE_THRESHOLD_EN
        do_reset();
        window(16, 5, 1'b1);
        idle(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            window(16, 1, 1'b1);
            idle(1'b0, 1'b1);
        end
        check("thr_after_refr", thr_o, 72);
        for (int i = 0; i < 15; i++) send(5, 1'b1, 1'b0);
        send(1, 1'b1, 1'b1);
        idle(1'b0, 1'b1);
        check("thr_nofire", spike, 0);
        check("thr_vl67", mem, 67);
        check("thr71", thr_o, 71);
`endif

        // inhibitory saturation
        do_reset();
        repeat (600) send(15, 1'b0, 1'b0);
        check("sat_low", mem, -2048);
        send(1, 1'b1, 1'b0);
        check("sat_plus1", mem, -2047);

        // asynchronous reset mid-window and with a spike pending in EVAL
        do_reset();
        window(5, 10, 1'b1);
        #2;
        do_reset();
        window(16, 5, 1'b1);
        #2;
        do_reset();
        idle(1'b0, 1'b1);
        check("spike_lost", spike, 0);
        idle(1'b0, 1'b1);

        // backpressure: continuous valid across window boundaries
        do_reset();
        for (int i = 0; i < 48; i++) send($urandom_range(0, 15), $urandom_range(0, 3) != 0, (i % 16) == 15);

        // enable low mid-window freezes state and drops window_end
        do_reset();
        window(8, 4, 1'b0);
        window(8, 4, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) send(4, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 15, 1'b1, 1'b1, 1'b0, acc);
        check("frozen", mem, 32);
        idle(1'b0, 1'b1);
        check("en_we_dropped", syn_if.syn_ready, 1);
        check("frozen_after", mem, 32);

        // randomized windows with gaps and enable drops
        do_reset();
        for (int win = 0; win < 40; win++) begin
            for (int b = 0; b < 16; b++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
                w = $urandom_range(0, 15);
                if ($urandom_range(0, 9) == 0) step(1'b1, w, 1'b1, b == 15, 1'b0, acc);
                send(w, $urandom_range(0, 3) != 0, b == 15);
            end
        end
        idle(1'b0, 1'b1);
        idle(1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
